ssd_display_arbiter: RTL and testbench
======================================

SSD_DISPLAY_ARBITER -- requirements
Module: ssd_display_arbiter

Interface
REQ-001 Parameter SCAN_DIV, default 13000: clk cycles per digit slot; legal range >= 20.
REQ-002 Parameter BLINK_FRAMES, default 25: frames per blink-phase toggle; legal range >= 1.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 req  in  4  display requests; bit 0 time-of-day, 1 alarm-set, 2 stopwatch, 3 kitchen timer.
REQ-006 urgent  in  4  per-source urgent flag (alarm ringing); meaningful only where req is also set.
REQ-007 src_val  in  56  four 14-bit values; source i occupies bits [14i+13:14i].
REQ-008 blink_en  in  1  blanks the display during blink phase 1.
REQ-009 an  out  4  digit anodes, active-low one-cold.
REQ-010 seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 grant  out  4  one-hot source shown in current frame; 0000 = blank.
REQ-012 frame_start  out  1  one-cycle pulse on the first cycle of each frame.

Function
REQ-013 Scan: slot counter 0..SCAN_DIV-1; digit index 0..3 advances on counter wrap; frame = 4 slots = 4*SCAN_DIV cycles.
REQ-014 Digit order: index 0 ones (an=1110), 1 tens (1101), 2 hundreds (1011), 3 thousands (0111).
REQ-015 Arbitration occurs only on frame_start; grant is constant for the whole frame.
REQ-016 Priority: any req&urgent -> lowest such index; else current grant kept if its req still set (sticky); else lowest set req bit; else grant=0000.
REQ-017 On frame_start, granted src_val is captured; values >9999 saturate to 9999 before conversion.
REQ-018 Converter FSM: IDLE -> SHIFT (14 cycles, shift-add-3 binary-to-BCD) -> DONE -> IDLE; start = frame_start with grant nonzero.
REQ-019 Converted digits are written to the display register at the next frame_start, so the value captured in frame N is shown throughout frame N+1; a frame never shows mixed digits.
REQ-020 grant registered with the captured value is likewise delayed one frame for the display path; output grant reflects the arbitration decision immediately.
REQ-021 Empty frame (grant=0000) shown in frame N+1 as an=1111, seg=1111111.
REQ-022 Blink phase toggles every BLINK_FRAMES frames; blink_en=1 and phase=1 force an=1111; blink_en never alters arbitration or conversion.
REQ-023 Segment codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; any other nibble = 1111111.
REQ-024 req dropping mid-frame has no effect until next frame_start; src_val changes mid-frame are ignored.
REQ-025 Urgent assertion on a source different from current grant switches grant at the next frame_start, overriding stickiness.
REQ-026 All outputs registered; no combinational input-to-output path.

Reset
REQ-027 rst_n low asynchronously forces an=1111, seg=1111111, grant=0000, frame_start=0, counters 0, blink phase 0, converter IDLE, display register marked invalid.
REQ-028 First frame_start occurs SCAN_DIV*4 cycles after rst_n deasserts; display stays blank until the frame following the first conversion.
REQ-029 Reset mid-conversion discards the partial result; no stale digits appear after reset.

Structure
REQ-030 Shared package holds source index constants (SRC_TOD=0, SRC_ALM=1, SRC_SW=2, SRC_KT=3), VAL_W=14, VAL_MAX=9999 and the segment-code table.
REQ-031 Binary-to-BCD converter is one sub-module, bcd_converter_seq (start, busy, done, 14-bit in, 16-bit BCD out).

Verification
REQ-032 SCAN_DIV=20; req=0001, src_val[13:0]=1234 -> frame 2 shows an 1110/1101/1011/0111 with seg 4/3/2/1 codes, 20 cycles each.
REQ-033 req=0101 sticky on source 2; then req=0111 -> grant stays 0100; drop bit 2 -> next frame grant=0001.
REQ-034 grant=0001, assert urgent[3] with req[3] -> next frame_start grant=1000; release -> grant returns to 0001 (lowest set).
REQ-035 src_val=12000 -> display 9999; src_val=7 -> digits 0,0,0,7; req=0000 -> next-but-one frame fully blank.
REQ-036 BLINK_FRAMES=2, blink_en=1 -> two frames lit, two frames an=1111, repeating; grant unaffected.
REQ-037 rst_n pulsed low mid-SHIFT -> outputs immediately blank; first lit frame is the second frame after release.

Source files
------------

// File: rtl/ssd_display_arbiter_pkg.sv
// Shared constants, segment table and arbitration helpers for the
// four-digit display arbiter.
package ssd_display_arbiter_pkg;

  localparam int NUM_SRC = 4;
  localparam int SRC_TOD = 0;
  localparam int SRC_ALM = 1;
  localparam int SRC_SW  = 2;
  localparam int SRC_KT  = 3;
  localparam int VAL_W   = 14;
  localparam int VAL_MAX = 9999;
  localparam int BCD_W   = 16;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // {g,f,e,d,c,b,a}, active-low, indexed by decimal digit
  localparam logic [6:0] SEG_TABLE [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef enum logic [1:0] {
    CONV_IDLE  = 2'd0,
    CONV_SHIFT = 2'd1,
    CONV_DONE  = 2'd2
  } conv_state_t;

  function automatic logic [6:0] seg_code(input logic [3:0] nib);
    logic [6:0] code;
    code = SEG_BLANK;
    if (nib <= 4'd9) code = SEG_TABLE[nib];
    return code;
  endfunction

  function automatic logic [NUM_SRC-1:0] lowest_bit(input logic [NUM_SRC-1:0] x);
    return x & (~x + NUM_SRC'(1));
  endfunction

  // Urgent beats sticky, sticky beats plain lowest-index request.
  function automatic logic [NUM_SRC-1:0] arbitrate(
    input logic [NUM_SRC-1:0] cur,
    input logic [NUM_SRC-1:0] req,
    input logic [NUM_SRC-1:0] urgent
  );
    logic [NUM_SRC-1:0] hot;
    logic [NUM_SRC-1:0] g;
    hot = req & urgent;
    if (hot != '0)              g = lowest_bit(hot);
    else if ((req & cur) != '0) g = cur;
    else                        g = lowest_bit(req);
    return g;
  endfunction

  function automatic logic [VAL_W-1:0] select_src(
    input logic [NUM_SRC-1:0]       g,
    input logic [NUM_SRC*VAL_W-1:0] vals
  );
    logic [VAL_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (g[i]) r = vals[i*VAL_W +: VAL_W];
    return r;
  endfunction

  function automatic logic [VAL_W-1:0] saturate(input logic [VAL_W-1:0] v);
    return (v > VAL_W'(VAL_MAX)) ? VAL_W'(VAL_MAX) : v;
  endfunction

endpackage

// File: rtl/ssd_display_arbiter_bcd.sv
// Sequential shift-add-3 binary-to-BCD converter, one input bit per cycle.
//   state      | meaning
//   CONV_IDLE  | waiting for start
//   CONV_SHIFT | adjust nibbles >= 5 by +3, then shift left (VAL_W cycles)
//   CONV_DONE  | result valid on bcd_out, done pulses for this cycle
module bcd_converter_seq
  import ssd_display_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [VAL_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd_out
);

  conv_state_t              state;
  logic [3:0]               bit_cnt;
  logic [VAL_W-1:0]         bin_sr;
  logic [BCD_W-1:0]         bcd_sr;
  logic [BCD_W-1:0]         bcd_adj;
  logic [BCD_W+VAL_W-1:0]   step;

  always_comb begin
    bcd_adj = bcd_sr;
    for (int d = 0; d < 4; d++)
      if (bcd_sr[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_sr[4*d +: 4] + 4'd3;
    step = {bcd_adj, bin_sr} << 1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CONV_IDLE;
      bit_cnt <= '0;
      bin_sr  <= '0;
      bcd_sr  <= '0;
      bcd_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        CONV_IDLE: begin
          done <= 1'b0;
          if (start) begin
            bin_sr  <= bin_in;
            bcd_sr  <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= CONV_SHIFT;
          end
        end
        CONV_SHIFT: begin
          bcd_sr  <= step[VAL_W +: BCD_W];
          bin_sr  <= step[VAL_W-1:0];
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'(VAL_W - 1)) begin
            bcd_out <= step[VAL_W +: BCD_W];
            done    <= 1'b1;
            state   <= CONV_DONE;
          end
        end
        CONV_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= CONV_IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= CONV_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/ssd_display_arbiter.sv
// Four-digit multiplexed seven-segment display shared by four sources;
// one source is arbitrated per frame and shown, converted, one frame later.
module ssd_display_arbiter
  import ssd_display_arbiter_pkg::*;
#(
  parameter int SCAN_DIV     = 13000,
  parameter int BLINK_FRAMES = 25
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC-1:0]         req,
  input  logic [NUM_SRC-1:0]         urgent,
  input  logic [NUM_SRC*VAL_W-1:0]   src_val,
  input  logic                       blink_en,
  output logic [3:0]                 an,
  output logic [6:0]                 seg,
  output logic [NUM_SRC-1:0]         grant,
  output logic                       frame_start
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLK_W = $clog2(BLINK_FRAMES + 1);

  logic [CNT_W-1:0]   slot_cnt;
  logic [1:0]         digit_idx;
  logic [BLK_W-1:0]   blink_cnt;
  logic               blink_phase;
  logic [VAL_W-1:0]   cap_val;
  logic [BCD_W-1:0]   pend_bcd;
  logic [BCD_W-1:0]   disp_bcd;
  logic               pend_valid;
  logic               disp_valid;

  logic               conv_start;
  logic               conv_busy;
  logic               conv_done;
  logic [BCD_W-1:0]   conv_bcd;

  logic               slot_wrap;
  logic               frame_tick;
  logic               blink_wrap;
  logic               nxt_phase;
  logic               nxt_valid;
  logic               lit;
  logic [1:0]         nxt_idx;
  logic [NUM_SRC-1:0] nxt_grant;
  logic [BCD_W-1:0]   nxt_bcd;
  logic [3:0]         nxt_nib;

  // Outputs are registered from next-state values so an/seg line up with
  // digit_idx and the display register without a one-cycle lag.
  always_comb begin
    slot_wrap  = (slot_cnt == CNT_W'(SCAN_DIV - 1));
    frame_tick = slot_wrap && (digit_idx == 2'd3);
    nxt_idx    = slot_wrap ? digit_idx + 2'd1 : digit_idx;
    nxt_grant  = arbitrate(grant, req, urgent);
    blink_wrap = (blink_cnt == BLK_W'(BLINK_FRAMES - 1));
    nxt_phase  = (frame_tick && blink_wrap) ? ~blink_phase : blink_phase;
    nxt_valid  = frame_tick ? pend_valid : disp_valid;
    nxt_bcd    = frame_tick ? pend_bcd : disp_bcd;
    nxt_nib    = nxt_bcd[{nxt_idx, 2'b00} +: 4];
    lit        = nxt_valid && !(blink_en && nxt_phase);
  end

  assign conv_start = frame_start && (grant != '0) && !conv_busy;

  bcd_converter_seq u_bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (conv_start),
    .bin_in  (cap_val),
    .busy    (conv_busy),
    .done    (conv_done),
    .bcd_out (conv_bcd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt    <= '0;
      digit_idx   <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      cap_val     <= '0;
      pend_bcd    <= '0;
      disp_bcd    <= '0;
      pend_valid  <= 1'b0;
      disp_valid  <= 1'b0;
      grant       <= '0;
      frame_start <= 1'b0;
      an          <= 4'hF;
      seg         <= SEG_BLANK;
    end else begin
      slot_cnt    <= slot_wrap ? '0 : slot_cnt + CNT_W'(1);
      digit_idx   <= nxt_idx;
      frame_start <= frame_tick;
      blink_phase <= nxt_phase;
      if (frame_tick) begin
        blink_cnt  <= blink_wrap ? '0 : blink_cnt + BLK_W'(1);
        grant      <= nxt_grant;
        cap_val    <= saturate(select_src(nxt_grant, src_val));
        disp_bcd   <= pend_bcd;
        disp_valid <= pend_valid;
        pend_valid <= 1'b0;
      end else if (conv_done) begin
        pend_bcd   <= conv_bcd;
        pend_valid <= 1'b1;
      end
      an  <= lit ? ~(4'b0001 << nxt_idx) : 4'hF;
      seg <= lit ? seg_code(nxt_nib) : SEG_BLANK;
    end
  end

endmodule

// File: tb/tb_ssd_display_arbiter.sv
// Directed and random frame-level checks of ssd_display_arbiter against a
// decimal-arithmetic model of arbitration, one-frame display delay and blink.
module tb_ssd_display_arbiter;

  localparam int SD = 20;
  localparam int BF = 2;
  localparam int FRAME = 4 * SD;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  urgent;
  logic [55:0] src_val;
  logic        blink_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [3:0]  grant;
  logic        frame_start;

  int n_assert = 0;
  int n_fail   = 0;

  logic [6:0] seg_exp [10];

  // stimulus queued for the next arbitration, and what the DUT currently sees
  logic [3:0] n_req, n_urg, a_req, a_urg;
  int         n_val [4];
  int         a_val [4];
  bit         n_blink, a_blink;

  // reference model state
  logic [3:0] m_grant;
  bit         m_pend_ok, m_show_ok;
  int         m_pend_val, m_show_val;
  int         m_frame;

  ssd_display_arbiter #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .urgent      (urgent),
    .src_val     (src_val),
    .blink_en    (blink_en),
    .an          (an),
    .seg         (seg),
    .grant       (grant),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_arb(input logic [3:0] cur, input logic [3:0] r,
                                           input logic [3:0] u);
    for (int i = 0; i < 4; i++)
      if (r[i] && u[i]) return 4'(1 << i);
    if (cur != 0 && r[src_of(cur)]) return cur;
    for (int i = 0; i < 4; i++)
      if (r[i]) return 4'(1 << i);
    return 4'b0000;
  endfunction

  function automatic int src_of(input logic [3:0] g);
    int k = 0;
    for (int i = 0; i < 4; i++)
      if (g[i]) k = i;
    return k;
  endfunction

  function automatic int digit_of(input int v, input int pos);
    int p = 1;
    for (int i = 0; i < pos; i++) p = p * 10;
    return (v / p) % 10;
  endfunction

  task automatic set_next(input logic [3:0] r, input logic [3:0] u, input int v0,
                          input int v1, input int v2, input int v3, input bit b);
    n_req = r; n_urg = u; n_blink = b;
    n_val[0] = v0; n_val[1] = v1; n_val[2] = v2; n_val[3] = v3;
  endtask

  task automatic apply();
    req      = n_req;
    urgent   = n_urg;
    blink_en = n_blink;
    src_val  = {14'(n_val[3]), 14'(n_val[2]), 14'(n_val[1]), 14'(n_val[0])};
    a_req = n_req; a_urg = n_urg; a_blink = n_blink;
    for (int i = 0; i < 4; i++) a_val[i] = n_val[i];
  endtask

  task automatic model_reset();
    m_grant = 4'b0000; m_pend_ok = 0; m_show_ok = 0;
    m_pend_val = 0; m_show_val = 0; m_frame = 0;
  endtask

  task automatic summary_and_finish();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  endtask

  // Waits for the next frame_start, then checks every slot boundary of that
  // frame; the queued stimulus is applied on the frame's last cycle.
  task automatic run_frame(input int exp_wait);
    int waited = 0;
    bit ph, lit;
    int v, s;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (frame_start !== 1'b1 && waited < FRAME + 8);
    check("frame_start_spacing", waited, exp_wait);
    if (frame_start !== 1'b1) summary_and_finish();

    m_frame++;
    m_show_ok  = m_pend_ok;
    m_show_val = m_pend_val;
    m_grant    = model_arb(m_grant, a_req, a_urg);
    m_pend_ok  = (m_grant != 0);
    v          = m_pend_ok ? a_val[src_of(m_grant)] : 0;
    m_pend_val = (v > 9999) ? 9999 : v;
    ph         = ((m_frame / BF) % 2) == 1;
    lit        = m_show_ok && !(a_blink && ph);

    // inputs wander mid-frame; nothing visible may change
    req     = 4'($urandom);
    urgent  = 4'($urandom);
    src_val = {24'($urandom), 32'($urandom)};

    for (int c = 0; c < FRAME; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if ((c % SD) == 0 || (c % SD) == SD - 1) begin
        s     = c / SD;
        e_an  = lit ? ~(4'b0001 << s) : 4'b1111;
        e_seg = lit ? seg_exp[digit_of(m_show_val, s)] : 7'b1111111;
        check("an", an, e_an);
        check("seg", seg, e_seg);
        check("grant", grant, m_grant);
        check("frame_start_pulse", frame_start, (c == 0) ? 1'b1 : 1'b0);
      end
    end
    apply();
  endtask

  initial begin
    seg_exp[0] = 7'b1000000; seg_exp[1] = 7'b1111001; seg_exp[2] = 7'b0100100;
    seg_exp[3] = 7'b0110000; seg_exp[4] = 7'b0011001; seg_exp[5] = 7'b0010010;
    seg_exp[6] = 7'b0000010; seg_exp[7] = 7'b1111000; seg_exp[8] = 7'b0000000;
    seg_exp[9] = 7'b0010000;

    rst_n = 1'b0; req = '0; urgent = '0; src_val = '0; blink_en = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_an", an, 4'b1111);
    check("rst_seg", seg, 7'b1111111);
    check("rst_grant", grant, 4'b0000);
    check("rst_frame_start", frame_start, 1'b0);

    // time-of-day 1234: blank first frame, digits in the second
    set_next(4'b0001, 4'b0000, 1234, 42, 5678, 305, 0);
    apply();
    @(posedge clk); #1 rst_n = 1'b1;
    run_frame(FRAME);
    run_frame(1);

    // stickiness on source 2, then hand back to source 0
    set_next(4'b0100, 4'b0000, 1234, 42, 5678, 305, 0); run_frame(1);
    set_next(4'b0101, 4'b0000, 1234, 42, 5678, 305, 0); run_frame(1);
    set_next(4'b0111, 4'b0000, 1234, 42, 5678, 305, 0); run_frame(1);
    set_next(4'b0011, 4'b0000, 1234, 42, 5678, 305, 0); run_frame(1);
    run_frame(1);

    // urgent kitchen timer preempts, then releases
    set_next(4'b1011, 4'b1000, 1234, 42, 5678, 305, 0); run_frame(1);
    set_next(4'b0011, 4'b0000, 1234, 42, 5678, 305, 0); run_frame(1);
    run_frame(1);

    // saturation, leading zeros, empty frames
    set_next(4'b0001, 4'b0000, 12000, 42, 5678, 305, 0); run_frame(1);
    set_next(4'b0001, 4'b0000, 7, 42, 5678, 305, 0);     run_frame(1);
    set_next(4'b0000, 4'b0000, 7, 42, 5678, 305, 0);     run_frame(1);
    run_frame(1);
    run_frame(1);

    // blinking stopwatch
    set_next(4'b0100, 4'b0000, 1, 2, 5678, 4, 1);
    repeat (6) run_frame(1);

    // random traffic
    for (int k = 0; k < 20; k++) begin
      set_next(4'($urandom_range(0, 15)),
               ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
               ($urandom_range(0, 4) == 0) ? 10000 : int'($urandom_range(0, 16383)),
               int'($urandom_range(0, 9999)),
               ($urandom_range(0, 4) == 0) ? 9999 : int'($urandom_range(0, 16383)),
               int'($urandom_range(0, 16383)),
               bit'($urandom_range(0, 1)));
      run_frame(1);
    end

    // reset in the middle of a conversion
    set_next(4'b0100, 4'b0000, 1, 2, 8642, 4, 0); run_frame(1);
    run_frame(1);
    @(posedge clk); #1;
    check("pre_reset_frame_start", frame_start, 1'b1);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midshift_rst_an", an, 4'b1111);
    check("midshift_rst_seg", seg, 7'b1111111);
    check("midshift_rst_grant", grant, 4'b0000);
    check("midshift_rst_frame_start", frame_start, 1'b0);
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    run_frame(FRAME);
    run_frame(1);
    run_frame(1);

    summary_and_finish();
  end

endmodule
